// File: rtl/tristate_bus_reader.sv
// Receiving-end controller for a shared tristate bus whose remote driver has
// an active-low output enable. A read opens the driver, waits a settle time,
// double-samples the bus, retries unstable reads a bounded number of times,
// then closes the driver for a turnaround gap. Each good word is handed over
// through a one-entry valid/ready buffer.
module tristate_bus_reader #(
  parameter int DATA_W    = 16,
  parameter int SETTLE    = 2,  // cycles the driver is open before the first sample (>= 1)
  parameter int TURN      = 1,  // cycles the driver stays closed after a read (>= 1)
  parameter int MAX_RETRY = 3   // mismatched double-samples per read before abort (>= 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] bus_in,
  output logic              oe_n,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TURN + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TURN_LAST   = TW'(TURN - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_CHECK,
    ST_TURN
  } state_t;

  state_t              state_reg,  state_next;
  logic [SW-1:0]       settle_reg, settle_next;
  logic [TW-1:0]       turn_reg,   turn_next;
  logic [RW-1:0]       retry_reg,  retry_next;
  logic [DATA_W-1:0]   s1_reg,     s1_next;
  logic [DATA_W-1:0]   data_reg,   data_next;
  logic                valid_reg,  valid_next;
  logic                err_reg,    err_next;
  logic                oe_n_reg,   oe_n_next;

  // The output buffer can take a new word if it is empty or being drained now.
  logic buf_free;
  assign buf_free = !valid_reg || ready;

  // Next-state, counter, sample and output-buffer logic.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    turn_next   = turn_reg;
    retry_next  = retry_reg;
    s1_next     = s1_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    err_next    = 1'b0;

    // Handshake drains the buffer; a fresh capture below overrides this.
    if (valid_reg && ready) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        // Gating on the buffer guarantees it is empty by the time CHECK
        // delivers, so a word is never overwritten.
        if (req && buf_free) begin
          state_next  = ST_ENABLE;
          settle_next = '0;
          retry_next  = '0;
        end
      end

      ST_ENABLE: begin
        if (settle_reg == SETTLE_LAST) begin
          s1_next     = bus_in;
          settle_next = '0;
          state_next  = ST_CHECK;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      ST_CHECK: begin
        if (bus_in == s1_reg) begin
          data_next  = s1_reg;
          valid_next = 1'b1;
          retry_next = '0;
          turn_next  = '0;
          state_next = ST_TURN;
        end else if (retry_reg == RETRY_LAST) begin
          // Out of retries: flag the abort, leave the buffer untouched.
          err_next   = 1'b1;
          retry_next = '0;
          turn_next  = '0;
          state_next = ST_TURN;
        end else begin
          // Unstable read: settle again with the driver still open.
          retry_next  = retry_reg + 1'b1;
          settle_next = '0;
          state_next  = ST_ENABLE;
        end
      end

      ST_TURN: begin
        if (turn_reg == TURN_LAST) begin
          turn_next  = '0;
          state_next = ST_IDLE;
        end else begin
          turn_next = turn_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Driver is open exactly while the next state is ENABLE or CHECK, so the
    // registered enable lines up with the state register.
    oe_n_next = !((state_next == ST_ENABLE) || (state_next == ST_CHECK));
  end

  // State and datapath registers; reset closes the driver at once and drops
  // any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      settle_reg <= '0;
      turn_reg   <= '0;
      retry_reg  <= '0;
      s1_reg     <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      oe_n_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      turn_reg   <= turn_next;
      retry_reg  <= retry_next;
      s1_reg     <= s1_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      oe_n_reg   <= oe_n_next;
    end
  end

  assign oe_n     = oe_n_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign data_out = data_reg;
  assign valid    = valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed bench for tristate_bus_reader: default instance (SETTLE=2, TURN=1,
// MAX_RETRY=3) plus a SETTLE=1, TURN=3 instance for back-to-back reads.
module tb_tristate_bus_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, ready, oe_n, busy, valid, err;
  logic [15:0] bus_in, data_out;
  logic        req_b, ready_b, oe_n_b, busy_b, valid_b, err_b;
  logic [15:0] bus_b, data_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tristate_bus_reader #(.DATA_W(16), .SETTLE(2), .TURN(1), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bus_in(bus_in), .oe_n(oe_n),
    .busy(busy), .data_out(data_out), .valid(valid), .ready(ready), .err(err)
  );

  tristate_bus_reader #(.DATA_W(16), .SETTLE(1), .TURN(3), .MAX_RETRY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .bus_in(bus_b), .oe_n(oe_n_b),
    .busy(busy_b), .data_out(data_b), .valid(valid_b), .ready(ready_b), .err(err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_low, err_cnt, err_idx, valid_seen, busy10, oe9;
    logic [15:0] words [3];
    words[0] = 16'hBEEF;
    words[1] = 16'h0001;
    words[2] = 16'h8000;

    rst_n = 1'b0; req = 1'b0; ready = 1'b1; bus_in = '0;
    req_b = 1'b0; ready_b = 1'b1; bus_b = '0;
    tick; tick;
    check("rst_oe_n", oe_n, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_data", data_out, 0);
    check("rst_b_oe_n", oe_n_b, 1);
    rst_n = 1'b1;
    tick;

    // 1: plain read, OE_N low for 3 cycles, VALID at E0+3
    bus_in = 16'hA5C3; ready = 1'b1; req = 1'b1;
    tick; req = 1'b0;
    check("t1_e0_oe_n", oe_n, 0);
    check("t1_e0_busy", busy, 1);
    tick;
    check("t1_e1_oe_n", oe_n, 0);
    check("t1_e1_valid", valid, 0);
    tick;
    check("t1_e2_oe_n", oe_n, 0);
    check("t1_e2_valid", valid, 0);
    tick;
    check("t1_e3_oe_n", oe_n, 1);
    check("t1_e3_valid", valid, 1);
    check("t1_e3_data", data_out, 16'hA5C3);
    check("t1_e3_err", err, 0);
    check("t1_e3_busy", busy, 1);
    tick;
    check("t1_e4_valid", valid, 0);
    check("t1_e4_busy", busy, 0);
    check("t1_e4_oe_n", oe_n, 1);

    // 2: backpressure holds the word and blocks the next read
    ready = 1'b0; bus_in = 16'h5A5A; req = 1'b1;
    tick; tick; tick; tick;
    check("t2_valid", valid, 1);
    check("t2_data", data_out, 16'h5A5A);
    bus_in = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("t2_hold_valid", valid, 1);
      check("t2_hold_data", data_out, 16'h5A5A);
      check("t2_hold_oe_n", oe_n, 1);
    end
    ready = 1'b1; bus_in = 16'h0F0F;
    tick;
    check("t2_drain_valid", valid, 0);
    check("t2_restart_oe_n", oe_n, 0);
    check("t2_restart_busy", busy, 1);
    req = 1'b0;
    tick; tick; tick;
    check("t2_next_valid", valid, 1);
    check("t2_next_data", data_out, 16'h0F0F);
    tick;
    check("t2_next_drain", valid, 0);

    // 3: one mismatch on the first attempt, then a good read
    bus_in = 16'h1234; req = 1'b1; oe_low = 0; err_cnt = 0;
    tick; req = 1'b0;
    if (!oe_n) oe_low++;
    tick;
    if (!oe_n) oe_low++;
    tick;
    if (!oe_n) oe_low++;
    bus_in = 16'h1235;
    for (int i = 0; i < 15 && !valid; i++) begin
      tick;
      if (!oe_n) oe_low++;
      if (err) err_cnt++;
    end
    check("t3_valid", valid, 1);
    check("t3_oe_low_cycles", oe_low, 6);
    check("t3_data", data_out, 16'h1235);
    check("t3_err", err_cnt, 0);
    tick;

    // 4: bus toggling every cycle exhausts the retries
    bus_in = 16'h0000; req = 1'b1;
    oe_low = 0; err_cnt = 0; err_idx = -1; valid_seen = 0; busy10 = -1; oe9 = -1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (i == 0) req = 1'b0;
      if (!oe_n) oe_low++;
      if (err) begin err_cnt++; err_idx = i; end
      if (valid) valid_seen++;
      if (i == 9) oe9 = int'(oe_n);
      if (i == 10) busy10 = int'(busy);
      bus_in = ~bus_in;
    end
    check("t4_err_pulses", err_cnt, 1);
    check("t4_err_cycle", err_idx, 9);
    check("t4_valid_seen", valid_seen, 0);
    check("t4_oe_low_cycles", oe_low, 9);
    check("t4_oe_n_at_err", oe9, 1);
    check("t4_busy_after_turn", busy10, 0);

    // 5a: reset discards a pending word without a clock edge
    ready = 1'b0; bus_in = 16'hC0DE; req = 1'b1;
    tick; req = 1'b0;
    tick; tick; tick;
    check("t5_pending_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_data", data_out, 0);
    check("t5_rst_busy", busy, 0);
    #1 rst_n = 1'b1;
    tick;

    // 5b: reset during ENABLE closes the driver immediately
    ready = 1'b1; req = 1'b1;
    tick; req = 1'b0;
    tick;
    check("t5_enable_oe_n", oe_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_oe_n", oe_n, 1);
    check("t5_async_valid", valid, 0);
    check("t5_async_busy", busy, 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("t5_idle_oe_n", oe_n, 1);
      check("t5_idle_busy", busy, 0);
    end

    // 6: SETTLE=1, TURN=3, REQ held: 2 low, then 3 TURN + 1 IDLE high, period 6
    bus_b = words[0]; ready_b = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick;
      check("t6_oe_n", oe_n_b, ((i % 6) < 2) ? 32'd0 : 32'd1);
      check("t6_valid", valid_b, ((i % 6) == 2) ? 32'd1 : 32'd0);
      if ((i % 6) == 2) begin
        check("t6_data", data_b, words[i / 6]);
        if ((i / 6) < 2) bus_b = words[i / 6 + 1];
      end
    end
    req_b = 1'b0;
    tick;
    check("t6_err", err_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
